// File: rtl/md_issue_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// md_issue_ctrl_pkg
// Shared M-extension definitions for the divide issue controller:
//   - divide-class op encodings (ex_op[2] set marks a divide-class op)
//   - issue FSM state encoding (also exported on the debug state port)
// ---------------------------------------------------------------------------
package md_issue_ctrl_pkg;

  localparam logic [2:0] OP_DIV  = 3'b100;
  localparam logic [2:0] OP_DIVU = 3'b101;
  localparam logic [2:0] OP_REM  = 3'b110;
  localparam logic [2:0] OP_REMU = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_RESP  = 3'd4
  } md_state_e;

  // Divide-class ops all have bit 2 set; anything else is not ours.
  function automatic logic is_div_class(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/md_result_cache.sv
// ---------------------------------------------------------------------------
// md_result_cache
// Single-entry last-result cache: remembers {op, rs1, rs2, result} of the
// most recently completed divide and flags a hit when a new request carries
// identical op and operands.
// Ports:
//   clk, reset                      clock, async active-high reset
//   i_lk_op/i_lk_rs1/i_lk_rs2       lookup key (incoming request)
//   o_hit, o_result                 hit flag and cached result
//   i_wr_en                         write the entry (divider completion)
//   i_wr_op/i_wr_rs1/i_wr_rs2       key of the completed operation
//   i_wr_result                     result of the completed operation
// ---------------------------------------------------------------------------
module md_result_cache #(
  parameter int CACHE_EN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  i_lk_op,
  input  logic [31:0] i_lk_rs1,
  input  logic [31:0] i_lk_rs2,
  output logic        o_hit,
  output logic [31:0] o_result,
  input  logic        i_wr_en,
  input  logic [2:0]  i_wr_op,
  input  logic [31:0] i_wr_rs1,
  input  logic [31:0] i_wr_rs2,
  input  logic [31:0] i_wr_result
);

  logic        r_valid;
  logic [2:0]  r_op;
  logic [31:0] r_rs1;
  logic [31:0] r_rs2;
  logic [31:0] r_result;
  logic        w_match;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid  <= 1'b0;
      r_op     <= 3'd0;
      r_rs1    <= 32'd0;
      r_rs2    <= 32'd0;
      r_result <= 32'd0;
    end else if (i_wr_en) begin
      r_valid  <= 1'b1;
      r_op     <= i_wr_op;
      r_rs1    <= i_wr_rs1;
      r_rs2    <= i_wr_rs2;
      r_result <= i_wr_result;
    end
  end

  assign w_match  = (r_op == i_lk_op) && (r_rs1 == i_lk_rs1) && (r_rs2 == i_lk_rs2);
  assign o_hit    = (CACHE_EN != 0) && r_valid && w_match;
  assign o_result = r_result;

endmodule

// File: rtl/md_issue_ctrl.sv
// ---------------------------------------------------------------------------
// md_issue_ctrl
// Issue controller between the EX stage and a multi-cycle divider. Accepts
// one divide-class instruction at a time, either answers it from the
// last-result cache or launches the divider, and holds the result for
// writeback. Supports flush of the in-flight instruction.
//
// Handshakes:
//   EX request : accepted on a rising edge where ex_valid && ex_ready.
//                ex_ready is high only in IDLE with flush low.
//   Divider    : md_type is a one-cycle start strobe; md_alu_done is a
//                one-cycle completion pulse with md_result valid alongside.
//   Writeback  : wb_valid/wb_rd/wb_data stay stable until consumed on an
//                edge where wb_valid && wb_ready (or dropped by flush).
//
// Ports:
//   clk, reset                        clock, async active-high reset
//   ex_valid/ex_op/ex_rs1/ex_rs2/ex_rd request from EX
//   ex_ready, pipe_stall              request accept / pipeline stall
//   md_type, md_operation             divider start strobe and op
//   alu_in1, alu_in2                  divider operands
//   md_result, md_alu_stall, md_alu_done  divider result/busy/done
//   wb_valid, wb_rd, wb_data, wb_ready writeback handshake
//   flush                             kill in-flight instruction
//   dbg_state                         current FSM state (debug)
// ---------------------------------------------------------------------------
module md_issue_ctrl
  import md_issue_ctrl_pkg::*;
#(
  parameter int CACHE_EN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [2:0]  ex_op,
  input  logic [31:0] ex_rs1,
  input  logic [31:0] ex_rs2,
  input  logic [4:0]  ex_rd,
  output logic        ex_ready,
  output logic        pipe_stall,
  output logic        md_type,
  output logic [2:0]  md_operation,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  input  logic [31:0] md_result,
  input  logic        md_alu_stall,
  input  logic        md_alu_done,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  input  logic        wb_ready,
  input  logic        flush,
  output logic [2:0]  dbg_state
);

  md_state_e   r_state;
  logic        r_md_type;
  logic [2:0]  r_op;
  logic [31:0] r_rs1;
  logic [31:0] r_rs2;
  logic [4:0]  r_rd;
  logic        r_wb_valid;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data;

  logic        w_idle;
  logic        w_accept;
  logic        w_hit;
  logic [31:0] w_hit_result;
  logic        w_cache_wr;

  assign w_idle   = (r_state == ST_IDLE);
  // Non-divide ops see ex_ready high but are never taken.
  assign w_accept = w_idle && !flush && ex_valid && is_div_class(ex_op);
  // Flushed (DRAIN) results still refresh the cache.
  assign w_cache_wr = md_alu_done && ((r_state == ST_WAIT) || (r_state == ST_DRAIN));

  md_result_cache #(.CACHE_EN(CACHE_EN)) u_cache (
    .clk         (clk),
    .reset       (reset),
    .i_lk_op     (ex_op),
    .i_lk_rs1    (ex_rs1),
    .i_lk_rs2    (ex_rs2),
    .o_hit       (w_hit),
    .o_result    (w_hit_result),
    .i_wr_en     (w_cache_wr),
    .i_wr_op     (r_op),
    .i_wr_rs1    (r_rs1),
    .i_wr_rs2    (r_rs2),
    .i_wr_result (md_result)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_md_type  <= 1'b0;
      r_op       <= 3'd0;
      r_rs1      <= 32'd0;
      r_rs2      <= 32'd0;
      r_rd       <= 5'd0;
      r_wb_valid <= 1'b0;
      r_wb_rd    <= 5'd0;
      r_wb_data  <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_hit) begin
              r_wb_data  <= w_hit_result;
              r_wb_rd    <= ex_rd;
              r_wb_valid <= 1'b1;
              r_state    <= ST_RESP;
            end else begin
              r_op      <= ex_op;
              r_rs1     <= ex_rs1;
              r_rs2     <= ex_rs2;
              r_rd      <= ex_rd;
              r_md_type <= 1'b1;
              r_state   <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          // The strobe is already out this cycle even under flush, so the
          // divider always sees a complete start and is drained afterwards.
          r_md_type <= 1'b0;
          r_state   <= flush ? ST_DRAIN : ST_WAIT;
        end
        ST_WAIT: begin
          if (md_alu_done) begin
            if (flush) begin
              r_state <= ST_IDLE;
            end else begin
              r_wb_data  <= md_result;
              r_wb_rd    <= r_rd;
              r_wb_valid <= 1'b1;
              r_state    <= ST_RESP;
            end
          end else if (flush) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (md_alu_done) r_state <= ST_IDLE;
        end
        ST_RESP: begin
          if (flush || wb_ready) begin
            r_wb_valid <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ex_ready     = w_idle && !flush;
  assign pipe_stall   = ex_valid && !ex_ready;
  assign md_type      = r_md_type;
  assign md_operation = r_op;
  assign alu_in1      = r_rs1;
  assign alu_in2      = r_rs2;
  assign wb_valid     = r_wb_valid;
  assign wb_rd        = r_wb_rd;
  assign wb_data      = r_wb_data;
  assign dbg_state    = r_state;

  a_no_start_done: assert property (@(posedge clk) disable iff (reset)
    !(md_type && md_alu_done));
  a_no_start_busy: assert property (@(posedge clk) disable iff (reset)
    md_type |-> !md_alu_stall);

endmodule

// File: tb/tb_md_issue_ctrl.sv
module tb_md_issue_ctrl;
  import md_issue_ctrl_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        ex_valid, ex_ready, pipe_stall, md_type, md_alu_stall, md_alu_done;
  logic        wb_valid, wb_ready, flush;
  logic [2:0]  ex_op, md_operation, dbg_state;
  logic [31:0] ex_rs1, ex_rs2, alu_in1, alu_in2, md_result, wb_data;
  logic [4:0]  ex_rd, wb_rd;

  int checks = 0;
  int errors = 0;
  int mdt_cnt = 0;
  int overlap_cnt = 0;

  md_issue_ctrl #(.CACHE_EN(1)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_op(ex_op), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_ready(ex_ready), .pipe_stall(pipe_stall),
    .md_type(md_type), .md_operation(md_operation), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .md_result(md_result), .md_alu_stall(md_alu_stall), .md_alu_done(md_alu_done),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ready(wb_ready),
    .flush(flush), .dbg_state(dbg_state)
  );

  // reference divide results (RISC-V M semantics)
  function automatic logic [31:0] ref_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (op)
      3'b100: if (b == 32'd0) r = 32'hFFFF_FFFF;
              else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
              else r = $signed(a) / $signed(b);
      3'b101: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'b110: if (b == 32'd0) r = a;
              else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
              else r = $signed(a) % $signed(b);
      default: r = (b == 32'd0) ? a : a % b;
    endcase
    return r;
  endfunction

  // divider responder: start seen -> 16 busy cycles -> done pulse
  int unsigned div_cnt;
  logic [31:0] div_res;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt     <= 0;
      md_alu_done <= 1'b0;
      md_result   <= 32'd0;
      div_res     <= 32'd0;
    end else begin
      md_alu_done <= 1'b0;
      if (md_type) begin
        div_cnt <= 16;
        div_res <= ref_div(md_operation, alu_in1, alu_in2);
      end else if (div_cnt != 0) begin
        div_cnt <= div_cnt - 1;
        if (div_cnt == 2) begin
          md_alu_done <= 1'b1;
          md_result   <= div_res;
        end
      end
    end
  end
  assign md_alu_stall = (div_cnt > 1);

  always @(posedge clk) begin
    if (md_type) mdt_cnt++;
    if (md_type && md_alu_done) overlap_cnt++;
  end

  // driver tasks
  task automatic do_issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output int lat, output logic mdt_first);
    @(negedge clk);
    ex_valid = 1'b1; ex_op = op; ex_rs1 = a; ex_rs2 = b; ex_rd = rd;
    #1;
    checks++;
    if (ex_ready !== 1'b1) begin
      errors++; $display("FAIL issue_ready: ex_ready=%b expected 1", ex_ready);
    end
    @(negedge clk);
    ex_valid = 1'b0;
    lat = 1;
    #1;
    mdt_first = md_type;
    while (wb_valid !== 1'b1 && lat < 40) begin
      @(negedge clk); #1; lat++;
    end
  endtask

  task automatic release_wb();
    @(negedge clk); wb_ready = 1'b1;
    @(negedge clk); wb_ready = 1'b0;
    #1;
    checks++;
    if (wb_valid !== 1'b0) begin
      errors++; $display("FAIL release_wb: wb_valid=%b expected 0", wb_valid);
    end
  endtask

  task automatic check_result(input string name, input int lat, input int exp_lat,
                              input logic [31:0] exp_data, input logic [4:0] exp_rd);
    checks++;
    if (lat != exp_lat) begin
      errors++; $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat);
    end
    checks++;
    if (wb_data !== exp_data || wb_rd !== exp_rd) begin
      errors++; $display("FAIL %s_data: wb_data=%h wb_rd=%0d expected %h/%0d", name, wb_data, wb_rd, exp_data, exp_rd);
    end
  endtask

  // scenarios
  task automatic test_reset();
    reset = 1'b1; ex_valid = 1'b0; ex_op = 3'd0; ex_rs1 = 32'd0; ex_rs2 = 32'd0; ex_rd = 5'd0;
    wb_ready = 1'b0; flush = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({md_type, wb_valid, pipe_stall, wb_rd, wb_data, alu_in1, alu_in2, md_operation, dbg_state} !== '0) begin
      errors++; $display("FAIL reset_values: md_type=%b wb_valid=%b wb_rd=%0d wb_data=%h in1=%h in2=%h op=%b st=%0d expected all 0",
                         md_type, wb_valid, wb_rd, wb_data, alu_in1, alu_in2, md_operation, dbg_state);
    end
    checks++;
    if (ex_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: ex_ready=%b expected 1", ex_ready);
    end
  endtask

  task automatic test_basic_div();
    int lat; logic m; int c0;
    c0 = mdt_cnt;
    do_issue(OP_DIV, 32'hFFFF_FFF9, 32'h2, 5'd5, lat, m);
    check_result("div_basic", lat, 18, 32'hFFFF_FFFD, 5'd5);
    checks++;
    if (m !== 1'b1 || (mdt_cnt - c0) != 1) begin
      errors++; $display("FAIL div_basic_strobe: md_type@T+1=%b pulses=%0d expected 1/1", m, mdt_cnt - c0);
    end
    release_wb();
  endtask

  task automatic test_div_zero();
    int lat; logic m;
    do_issue(OP_REMU, 32'h64, 32'h0, 5'd1, lat, m);
    check_result("remu_zero", lat, 18, 32'h0000_0064, 5'd1);
    release_wb();
    do_issue(OP_DIVU, 32'h64, 32'h0, 5'd2, lat, m);
    check_result("divu_zero", lat, 18, 32'hFFFF_FFFF, 5'd2);
    release_wb();
  endtask

  task automatic test_cache_hit();
    int lat; logic m; int c0;
    do_issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, lat, m);
    check_result("ovf_miss", lat, 18, 32'h8000_0000, 5'd7);
    release_wb();
    c0 = mdt_cnt;
    do_issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, lat, m);
    check_result("ovf_hit", lat, 1, 32'h8000_0000, 5'd8);
    checks++;
    if ((mdt_cnt - c0) != 0) begin
      errors++; $display("FAIL ovf_hit_no_strobe: pulses=%0d expected 0", mdt_cnt - c0);
    end
    release_wb();
  endtask

  task automatic test_flush_wait();
    int lat; logic m;
    @(negedge clk);
    ex_valid = 1'b1; ex_op = OP_DIV; ex_rs1 = 32'd100; ex_rs2 = 32'd7; ex_rd = 5'd3;
    #1;
    checks++;
    if (ex_ready !== 1'b1) begin
      errors++; $display("FAIL flush_wait_accept: ex_ready=%b expected 1", ex_ready);
    end
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      ex_valid = 1'b0;
      flush = (k == 5);
      #1;
      checks++;
      if (wb_valid !== 1'b0) begin
        errors++; $display("FAIL flush_wait_no_wb: cycle T+%0d wb_valid=%b expected 0", k, wb_valid);
      end
      if (k >= 6) begin
        checks++;
        if (ex_ready !== (k >= 18)) begin
          errors++; $display("FAIL flush_wait_ready: cycle T+%0d ex_ready=%b expected %b", k, ex_ready, (k >= 18));
        end
      end
    end
    flush = 1'b0;
    // drained result is in the cache
    do_issue(OP_DIV, 32'd100, 32'd7, 5'd4, lat, m);
    check_result("drain_cached", lat, 1, 32'd14, 5'd4);
    release_wb();
    do_issue(OP_DIV, 32'd10, 32'd3, 5'd6, lat, m);
    check_result("after_flush", lat, 18, 32'd3, 5'd6);
    release_wb();
  endtask

  task automatic test_flush_issue();
    int wb_seen; int n;
    @(negedge clk);
    ex_valid = 1'b1; ex_op = OP_DIVU; ex_rs1 = 32'd9; ex_rs2 = 32'd3; ex_rd = 5'd2;
    @(negedge clk);
    ex_valid = 1'b0; flush = 1'b1;
    #1;
    checks++;
    if (md_type !== 1'b1 || dbg_state !== ST_ISSUE) begin
      errors++; $display("FAIL flush_issue_strobe: md_type=%b state=%0d expected 1/%0d", md_type, dbg_state, ST_ISSUE);
    end
    @(negedge clk);
    flush = 1'b0;
    #1;
    checks++;
    if (md_type !== 1'b0 || dbg_state !== ST_DRAIN) begin
      errors++; $display("FAIL flush_issue_drain: md_type=%b state=%0d expected 0/%0d", md_type, dbg_state, ST_DRAIN);
    end
    wb_seen = 0; n = 0;
    while (ex_ready !== 1'b1 && n < 30) begin
      @(negedge clk); #1; n++;
      if (wb_valid === 1'b1) wb_seen++;
    end
    checks++;
    if (ex_ready !== 1'b1 || wb_seen != 0) begin
      errors++; $display("FAIL flush_issue_end: ex_ready=%b wb_cycles=%0d expected 1/0", ex_ready, wb_seen);
    end
  endtask

  task automatic test_backpressure();
    int lat; logic m;
    do_issue(OP_DIVU, 32'd20, 32'd4, 5'd9, lat, m);
    check_result("bp_first", lat, 18, 32'd5, 5'd9);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      ex_valid = 1'b1; ex_op = OP_DIV; ex_rs1 = 32'd1; ex_rs2 = 32'd1; wb_ready = 1'b0;
      #1;
      checks++;
      if ({wb_valid, wb_rd, wb_data, pipe_stall} !== {1'b1, 5'd9, 32'd5, 1'b1}) begin
        errors++; $display("FAIL bp_hold: cycle %0d wb_valid=%b wb_rd=%0d wb_data=%h pipe_stall=%b expected 1/9/5/1",
                           k, wb_valid, wb_rd, wb_data, pipe_stall);
      end
    end
    ex_valid = 1'b0;
    release_wb();
  endtask

  task automatic test_flush_resp();
    int lat; logic m;
    do_issue(OP_DIVU, 32'd20, 32'd4, 5'd10, lat, m);
    check_result("resp_hit", lat, 1, 32'd5, 5'd10);
    @(negedge clk);
    flush = 1'b1; wb_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; wb_ready = 1'b0;
    #1;
    checks++;
    if (wb_valid !== 1'b0 || dbg_state !== ST_IDLE) begin
      errors++; $display("FAIL flush_resp: wb_valid=%b state=%0d expected 0/0", wb_valid, dbg_state);
    end
  endtask

  task automatic test_flush_idle();
    int c0;
    c0 = mdt_cnt;
    @(negedge clk);
    ex_valid = 1'b1; ex_op = OP_DIV; ex_rs1 = 32'd50; ex_rs2 = 32'd5; flush = 1'b1;
    #1;
    checks++;
    if (ex_ready !== 1'b0 || pipe_stall !== 1'b1) begin
      errors++; $display("FAIL flush_idle_ready: ex_ready=%b pipe_stall=%b expected 0/1", ex_ready, pipe_stall);
    end
    @(negedge clk);
    #1;
    checks++;
    if (dbg_state !== ST_IDLE || (mdt_cnt - c0) != 0) begin
      errors++; $display("FAIL flush_idle_state: state=%0d pulses=%0d expected 0/0", dbg_state, mdt_cnt - c0);
    end
    ex_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic test_non_m_op();
    @(negedge clk);
    ex_valid = 1'b1; ex_op = 3'b001; ex_rs1 = 32'd8; ex_rs2 = 32'd2;
    #1;
    checks++;
    if (ex_ready !== 1'b1 || pipe_stall !== 1'b0) begin
      errors++; $display("FAIL non_m_ready: ex_ready=%b pipe_stall=%b expected 1/0", ex_ready, pipe_stall);
    end
    @(negedge clk);
    #1;
    checks++;
    if (dbg_state !== ST_IDLE || md_type !== 1'b0) begin
      errors++; $display("FAIL non_m_state: state=%0d md_type=%b expected 0/0", dbg_state, md_type);
    end
    ex_valid = 1'b0;
  endtask

  task automatic test_reset_wait();
    int lat; logic m;
    do_issue(OP_REM, 32'hFFFF_FFF9, 32'h2, 5'd11, lat, m);
    check_result("rem_neg", lat, 18, 32'hFFFF_FFFF, 5'd11);
    release_wb();
    @(negedge clk);
    ex_valid = 1'b1; ex_op = OP_DIV; ex_rs1 = 32'd50; ex_rs2 = 32'd5; ex_rd = 5'd13;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      ex_valid = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({md_type, wb_valid, pipe_stall, wb_rd, wb_data, alu_in1, alu_in2, md_operation, dbg_state} !== '0) begin
      errors++; $display("FAIL reset_wait_values: md_type=%b wb_valid=%b wb_rd=%0d wb_data=%h in1=%h in2=%h op=%b st=%0d expected all 0",
                         md_type, wb_valid, wb_rd, wb_data, alu_in1, alu_in2, md_operation, dbg_state);
    end
    reset = 1'b0;
    do_issue(OP_REM, 32'hFFFF_FFF9, 32'h2, 5'd12, lat, m);
    check_result("reset_miss", lat, 18, 32'hFFFF_FFFF, 5'd12);
    release_wb();
  endtask

  initial begin
    test_reset();
    test_basic_div();
    test_div_zero();
    test_cache_hit();
    test_flush_wait();
    test_flush_issue();
    test_backpressure();
    test_flush_resp();
    test_flush_idle();
    test_non_m_op();
    test_reset_wait();
    checks++;
    if (overlap_cnt != 0) begin
      errors++; $display("FAIL start_done_overlap: cycles=%0d expected 0", overlap_cnt);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
